controlador_ciclo: RTL and testbench

Central cycle sequencer for the bottle-filling line: a single Moore FSM that replaces the independent motor/filling/sealing/quality machines with one ordered sequence per bottle (advance → fill → seal → inspect → seal-stamp/discard → exit). It drives the conveyor motor, the filling valve and the sealer, and issues the one-cycle decrement/increment strobes consumed by the cork and bottle counters. It runs on the divided system clock, between the sensor/level-to-pulse front end and the counters/dispenser.

---
 rtl/vinhovasf_pkg.sv | 33 +++
 rtl/controlador_ciclo_temporizador.sv | 26 ++
 rtl/controlador_ciclo.sv | 182 ++++++++++++++++++
 tb/tb_controlador_ciclo.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vinhovasf_pkg.sv
// Shared types and constants for the bottle-filling line cycle sequencer.
// State encoding, fault codes and default timing values live here.
package vinhovasf_pkg;

    typedef enum logic [3:0] {
        EST_PARADO        = 4'd0,
        EST_AVANCO        = 4'd1,
        EST_ENCHENDO      = 4'd2,
        EST_AGUARDA_ROLHA = 4'd3,
        EST_VEDANDO       = 4'd4,
        EST_INSPECAO      = 4'd5,
        EST_LACRANDO      = 4'd6,
        EST_DESCARTANDO   = 4'd7,
        EST_SAIDA         = 4'd8,
        EST_FALHA         = 4'd9
    } estado_t;

    localparam logic [1:0] FALHA_NENHUMA    = 2'd0;
    localparam logic [1:0] FALHA_ESTEIRA    = 2'd1;
    localparam logic [1:0] FALHA_ENCHIMENTO = 2'd2;
    localparam logic [1:0] FALHA_INSPECAO   = 2'd3;

    localparam int unsigned T_AVANCO_MAX_PAD   = 40;
    localparam int unsigned T_ENCHER_MAX_PAD   = 20;
    localparam int unsigned T_VEDAR_PAD        = 2;
    localparam int unsigned T_INSPECAO_MAX_PAD = 30;
    localparam int unsigned T_LACRE_PAD        = 2;

    function automatic int unsigned maior(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controlador_ciclo_temporizador.sv
// Per-state dwell counter: cleared whenever the FSM changes state, saturates at
// all-ones, and flags when the count equals the current state's terminal value.
module temporizador_estado #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         limpa,
    input  logic [W-1:0] limite,
    output logic [W-1:0] contagem,
    output logic         fim
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (contagem != '1) begin
            contagem <= contagem + W'(1);
        end
    end

    assign fim = (contagem == limite);

endmodule

// File: rtl/controlador_ciclo.sv
// Central cycle sequencer: one Moore FSM ordering advance, fill, seal, inspect,
// stamp/discard and exit per bottle, with timeouts latched as fault codes.
module controlador_ciclo
    import vinhovasf_pkg::*;
#(
    parameter int unsigned T_AVANCO_MAX   = T_AVANCO_MAX_PAD,
    parameter int unsigned T_ENCHER_MAX   = T_ENCHER_MAX_PAD,
    parameter int unsigned T_VEDAR        = T_VEDAR_PAD,
    parameter int unsigned T_INSPECAO_MAX = T_INSPECAO_MAX_PAD,
    parameter int unsigned T_LACRE        = T_LACRE_PAD
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    input  logic       GARRAFA_PRESENTE,
    input  logic       SENSOR_NIVEL,
    input  logic       ROLHAS_DISPONIVEIS,
    input  logic       PULSO_APROVADA,
    input  logic       PULSO_REPROVADA,
    input  logic       LOTE_COMPLETO,
    output logic       MOTOR_ATIVO,
    output logic       VALVULA_EV,
    output logic       VEDAR,
    output logic       EM_INSPECAO,
    output logic       LACRE,
    output logic       DESCARTE,
    output logic       DECREMENTA_ROLHA,
    output logic       INCREMENTA_GARRAFA,
    output logic       FALHA,
    output logic [1:0] CODIGO_FALHA,
    output logic [3:0] ESTADO
);

    localparam int unsigned T_MAIOR = maior(maior(maior(T_AVANCO_MAX, T_ENCHER_MAX),
                                                  maior(T_VEDAR, T_INSPECAO_MAX)), T_LACRE);
    localparam int unsigned TW = $clog2(T_MAIOR) + 1;

    estado_t       estado;
    estado_t       estado_prox;
    logic [1:0]    codigo;
    logic [1:0]    codigo_prox;
    logic [TW-1:0] contagem;
    logic [TW-1:0] limite;
    logic          fim;
    logic          primeiro;

    temporizador_estado #(
        .W(TW)
    ) u_temporizador (
        .clk      (CLOCK),
        .rst      (RESET),
        .limpa    (estado_prox != estado),
        .limite   (limite),
        .contagem (contagem),
        .fim      (fim)
    );

    assign primeiro = (contagem == '0);

    // Terminal count is T-1 so bounded states last at most T cycles.
    always_comb begin
        limite = '1;
        case (estado)
            EST_AVANCO, EST_SAIDA:          limite = TW'(T_AVANCO_MAX - 1);
            EST_ENCHENDO:                   limite = TW'(T_ENCHER_MAX - 1);
            EST_VEDANDO:                    limite = TW'(T_VEDAR - 1);
            EST_INSPECAO:                   limite = TW'(T_INSPECAO_MAX - 1);
            EST_LACRANDO, EST_DESCARTANDO:  limite = TW'(T_LACRE - 1);
            default:                        limite = '1;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            estado <= EST_PARADO;
            codigo <= FALHA_NENHUMA;
        end else begin
            estado <= estado_prox;
            codigo <= codigo_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        codigo_prox = codigo;
        if (!START) begin
            estado_prox = EST_PARADO;
        end else begin
            case (estado)
                EST_PARADO: begin
                    if (!LOTE_COMPLETO) estado_prox = EST_AVANCO;
                end
                EST_AVANCO: begin
                    if (GARRAFA_PRESENTE) begin
                        estado_prox = EST_ENCHENDO;
                    end else if (LOTE_COMPLETO) begin
                        estado_prox = EST_PARADO;
                    end else if (fim) begin
                        estado_prox = EST_FALHA;
                        codigo_prox = FALHA_ESTEIRA;
                    end
                end
                EST_ENCHENDO: begin
                    if (SENSOR_NIVEL) begin
                        estado_prox = ROLHAS_DISPONIVEIS ? EST_VEDANDO : EST_AGUARDA_ROLHA;
                    end else if (!GARRAFA_PRESENTE) begin
                        estado_prox = EST_AVANCO;
                    end else if (fim) begin
                        estado_prox = EST_FALHA;
                        codigo_prox = FALHA_ENCHIMENTO;
                    end
                end
                EST_AGUARDA_ROLHA: begin
                    if (ROLHAS_DISPONIVEIS) estado_prox = EST_VEDANDO;
                end
                EST_VEDANDO: begin
                    if (fim) estado_prox = EST_INSPECAO;
                end
                EST_INSPECAO: begin
                    if (PULSO_REPROVADA) begin
                        estado_prox = EST_DESCARTANDO;
                    end else if (PULSO_APROVADA) begin
                        estado_prox = EST_LACRANDO;
                    end else if (fim) begin
                        estado_prox = EST_FALHA;
                        codigo_prox = FALHA_INSPECAO;
                    end
                end
                EST_LACRANDO, EST_DESCARTANDO: begin
                    if (fim) estado_prox = EST_SAIDA;
                end
                EST_SAIDA: begin
                    if (!GARRAFA_PRESENTE) begin
                        estado_prox = LOTE_COMPLETO ? EST_PARADO : EST_AVANCO;
                    end else if (fim) begin
                        estado_prox = EST_FALHA;
                        codigo_prox = FALHA_ESTEIRA;
                    end
                end
                EST_FALHA: begin
                    estado_prox = EST_FALHA;
                end
                default: begin
                    estado_prox = EST_PARADO;
                end
            endcase
        end
        if (estado_prox == EST_PARADO) codigo_prox = FALHA_NENHUMA;
    end

    always_comb begin
        MOTOR_ATIVO        = 1'b0;
        VALVULA_EV         = 1'b0;
        VEDAR              = 1'b0;
        EM_INSPECAO        = 1'b0;
        LACRE              = 1'b0;
        DESCARTE           = 1'b0;
        DECREMENTA_ROLHA   = 1'b0;
        INCREMENTA_GARRAFA = 1'b0;
        FALHA              = 1'b0;
        case (estado)
            EST_AVANCO, EST_SAIDA: MOTOR_ATIVO = 1'b1;
            EST_ENCHENDO:          VALVULA_EV  = 1'b1;
            EST_VEDANDO: begin
                VEDAR            = 1'b1;
                DECREMENTA_ROLHA = primeiro;
            end
            EST_INSPECAO:          EM_INSPECAO = 1'b1;
            EST_LACRANDO: begin
                LACRE              = 1'b1;
                INCREMENTA_GARRAFA = primeiro;
            end
            EST_DESCARTANDO:       DESCARTE = 1'b1;
            EST_FALHA:             FALHA    = 1'b1;
            default:               ;
        endcase
    end

    assign CODIGO_FALHA = codigo;
    assign ESTADO       = estado;

endmodule

// File: tb/tb_controlador_ciclo.sv
// Self-checking bench for controlador_ciclo: directed scenarios plus random
// stimulus, every cycle compared against a behavioural sequence model.
module tb_controlador_ciclo;

    localparam int T_AV = 40;
    localparam int T_EN = 20;
    localparam int T_VE = 2;
    localparam int T_IN = 30;
    localparam int T_LA = 2;

    localparam int F_PARADO = 0, F_AVANCO = 1, F_ENCHENDO = 2, F_AGUARDA = 3, F_VEDANDO = 4;
    localparam int F_INSPECAO = 5, F_LACRANDO = 6, F_DESCARTANDO = 7, F_SAIDA = 8, F_FALHA = 9;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       garrafa = 1'b0;
    logic       sensor = 1'b0;
    logic       rolhas = 1'b1;
    logic       aprovada = 1'b0;
    logic       reprovada = 1'b0;
    logic       lote = 1'b0;
    logic       motor, valvula, vedar, em_inspecao, lacre, descarte;
    logic       decrementa, incrementa, falha;
    logic [1:0] codigo_falha;
    logic [3:0] estado;

    int checks = 0;
    int errors = 0;
    int cnt_dec = 0, cnt_inc = 0, cnt_lacre = 0, cnt_desc = 0;

    // Model: which step of the bottle sequence we are in and for how many cycles.
    int         m_fase = F_PARADO;
    int         m_perm = 0;
    logic [1:0] m_cod = 2'd0;

    controlador_ciclo #(
        .T_AVANCO_MAX   (T_AV),
        .T_ENCHER_MAX   (T_EN),
        .T_VEDAR        (T_VE),
        .T_INSPECAO_MAX (T_IN),
        .T_LACRE        (T_LA)
    ) dut (
        .CLOCK              (clock),
        .RESET              (reset),
        .START              (start),
        .GARRAFA_PRESENTE   (garrafa),
        .SENSOR_NIVEL       (sensor),
        .ROLHAS_DISPONIVEIS (rolhas),
        .PULSO_APROVADA     (aprovada),
        .PULSO_REPROVADA    (reprovada),
        .LOTE_COMPLETO      (lote),
        .MOTOR_ATIVO        (motor),
        .VALVULA_EV         (valvula),
        .VEDAR              (vedar),
        .EM_INSPECAO        (em_inspecao),
        .LACRE              (lacre),
        .DESCARTE           (descarte),
        .DECREMENTA_ROLHA   (decrementa),
        .INCREMENTA_GARRAFA (incrementa),
        .FALHA              (falha),
        .CODIGO_FALHA       (codigo_falha),
        .ESTADO             (estado)
    );

    always #5 clock = ~clock;

    function automatic logic [14:0] saidas_dut();
        return {estado, codigo_falha, falha, motor, valvula, vedar, em_inspecao,
                lacre, descarte, decrementa, incrementa};
    endfunction

    task automatic modelo_passo();
        int prox;
        logic [1:0] pc;
        if (reset) begin
            m_fase = F_PARADO;
            m_perm = 0;
            m_cod  = 2'd0;
            return;
        end
        prox = m_fase;
        pc   = m_cod;
        if (!start) begin
            prox = F_PARADO;
            pc   = 2'd0;
        end else begin
            case (m_fase)
                F_PARADO:   if (!lote) prox = F_AVANCO;
                F_AVANCO: begin
                    if (garrafa) prox = F_ENCHENDO;
                    else if (lote) prox = F_PARADO;
                    else if (m_perm + 1 >= T_AV) begin prox = F_FALHA; pc = 2'd1; end
                end
                F_ENCHENDO: begin
                    if (sensor) prox = rolhas ? F_VEDANDO : F_AGUARDA;
                    else if (!garrafa) prox = F_AVANCO;
                    else if (m_perm + 1 >= T_EN) begin prox = F_FALHA; pc = 2'd2; end
                end
                F_AGUARDA:  if (rolhas) prox = F_VEDANDO;
                F_VEDANDO:  if (m_perm + 1 >= T_VE) prox = F_INSPECAO;
                F_INSPECAO: begin
                    if (reprovada) prox = F_DESCARTANDO;
                    else if (aprovada) prox = F_LACRANDO;
                    else if (m_perm + 1 >= T_IN) begin prox = F_FALHA; pc = 2'd3; end
                end
                F_LACRANDO, F_DESCARTANDO: if (m_perm + 1 >= T_LA) prox = F_SAIDA;
                F_SAIDA: begin
                    if (!garrafa) prox = lote ? F_PARADO : F_AVANCO;
                    else if (m_perm + 1 >= T_AV) begin prox = F_FALHA; pc = 2'd1; end
                end
                default: ;
            endcase
        end
        m_perm = (prox == m_fase) ? m_perm + 1 : 0;
        m_fase = prox;
        m_cod  = pc;
    endtask

    task automatic compara();
        logic [14:0] esp;
        logic [14:0] obt;
        esp = {4'(m_fase), m_cod, m_fase == F_FALHA,
               (m_fase == F_AVANCO) || (m_fase == F_SAIDA), m_fase == F_ENCHENDO,
               m_fase == F_VEDANDO, m_fase == F_INSPECAO, m_fase == F_LACRANDO,
               m_fase == F_DESCARTANDO, (m_fase == F_VEDANDO) && (m_perm == 0),
               (m_fase == F_LACRANDO) && (m_perm == 0)};
        obt = saidas_dut();
        checks++;
        if (obt !== esp) begin
            errors++;
            $display("FAIL saidas t=%0t obtido=%h esperado=%h", $time, obt, esp);
        end
        cnt_dec   += int'(decrementa);
        cnt_inc   += int'(incrementa);
        cnt_lacre += int'(lacre);
        cnt_desc  += int'(descarte);
    endtask

    task automatic ciclo();
        @(posedge clock);
        modelo_passo();
        #1;
        compara();
        #1;
    endtask

    task automatic verifica(input string nome, input int obtido, input int esperado);
        checks++;
        if (obtido != esperado) begin
            errors++;
            $display("FAIL %s obtido=%0d esperado=%0d", nome, obtido, esperado);
        end
    endtask

    task automatic espera_estado(input int alvo, input int limite);
        int n = 0;
        while (int'(estado) != alvo && n < limite) begin
            ciclo();
            n++;
        end
        verifica($sformatf("alcanca_estado_%0d", alvo), int'(estado), alvo);
    endtask

    task automatic pulso_aprovada();
        aprovada = 1'b1;
        ciclo();
        aprovada = 1'b0;
    endtask

    initial begin
        int b_dec, b_inc, b_lacre, b_desc, n, viol;

        ciclo();
        ciclo();
        verifica("reset_saidas", int'(saidas_dut()), 0);
        reset = 1'b0;
        start = 1'b1;

        // Nominal bottle
        b_dec = cnt_dec; b_inc = cnt_inc; b_lacre = cnt_lacre;
        ciclo();
        verifica("nominal_avanco", int'(estado), F_AVANCO);
        verifica("nominal_motor", int'(motor), 1);
        ciclo(); ciclo();
        garrafa = 1'b1;
        ciclo();
        verifica("nominal_enchendo", int'(estado), F_ENCHENDO);
        repeat (5) ciclo();
        sensor = 1'b1;
        ciclo();
        sensor = 1'b0;
        espera_estado(F_INSPECAO, 10);
        pulso_aprovada();
        espera_estado(F_SAIDA, 10);
        garrafa = 1'b0;
        ciclo();
        verifica("nominal_volta_avanco", int'(estado), F_AVANCO);
        verifica("nominal_dec", cnt_dec - b_dec, 1);
        verifica("nominal_inc", cnt_inc - b_inc, 1);
        verifica("nominal_lacre_ciclos", cnt_lacre - b_lacre, 2);

        // Both verdicts in the same cycle
        b_inc = cnt_inc; b_desc = cnt_desc;
        garrafa = 1'b1;
        ciclo();
        sensor = 1'b1;
        ciclo();
        sensor = 1'b0;
        espera_estado(F_INSPECAO, 10);
        aprovada = 1'b1; reprovada = 1'b1;
        ciclo();
        aprovada = 1'b0; reprovada = 1'b0;
        espera_estado(F_SAIDA, 10);
        verifica("descarte_ciclos", cnt_desc - b_desc, 2);
        verifica("descarte_sem_inc", cnt_inc - b_inc, 0);
        garrafa = 1'b0;
        ciclo();

        // Waiting for corks
        garrafa = 1'b1;
        ciclo();
        rolhas = 1'b0; sensor = 1'b1;
        ciclo();
        sensor = 1'b0;
        verifica("aguarda_rolha", int'(estado), F_AGUARDA);
        viol = 0;
        repeat (50) begin
            ciclo();
            if (motor || valvula || int'(estado) != F_AGUARDA) viol++;
        end
        verifica("aguarda_50_ciclos", viol, 0);
        rolhas = 1'b1;
        ciclo();
        verifica("rolha_volta_vedando", int'(estado), F_VEDANDO);
        espera_estado(F_INSPECAO, 10);
        pulso_aprovada();
        espera_estado(F_SAIDA, 10);
        garrafa = 1'b0;
        ciclo();

        // Fill timeout
        garrafa = 1'b1;
        ciclo();
        n = 0;
        while (int'(estado) == F_ENCHENDO && n < 40) begin
            n++;
            ciclo();
        end
        verifica("enchendo_ciclos", n, 20);
        verifica("falha_estado", int'(estado), F_FALHA);
        verifica("falha_codigo", int'(codigo_falha), 2);
        verifica("falha_saida", int'(falha), 1);
        start = 1'b0;
        ciclo();
        verifica("falha_para_parado", int'(estado), F_PARADO);
        verifica("falha_codigo_limpo", int'(codigo_falha), 0);

        // START dropped mid-sealing
        start = 1'b1;
        ciclo();
        ciclo();
        sensor = 1'b1;
        ciclo();
        sensor = 1'b0;
        b_inc = cnt_inc;
        verifica("vedando_antes_stop", int'(estado), F_VEDANDO);
        start = 1'b0;
        ciclo();
        verifica("stop_parado", int'(estado), F_PARADO);
        repeat (3) ciclo();
        verifica("stop_sem_inc", cnt_inc - b_inc, 0);

        // Asynchronous reset during inspection
        start = 1'b1;
        ciclo();
        ciclo();
        sensor = 1'b1;
        ciclo();
        sensor = 1'b0;
        espera_estado(F_INSPECAO, 10);
        reset = 1'b1;
        #1;
        verifica("reset_assincrono", int'(saidas_dut()), 0);
        ciclo();
        reset = 1'b0;

        // Batch complete during exit
        ciclo();
        ciclo();
        sensor = 1'b1;
        ciclo();
        sensor = 1'b0;
        espera_estado(F_INSPECAO, 10);
        pulso_aprovada();
        espera_estado(F_SAIDA, 10);
        lote = 1'b1; garrafa = 1'b0;
        ciclo();
        verifica("lote_parado", int'(estado), F_PARADO);
        repeat (5) ciclo();
        verifica("lote_mantem_parado", int'(estado), F_PARADO);
        verifica("lote_motor", int'(motor), 0);
        lote = 1'b0;

        // Randomized operation
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) garrafa = ~garrafa;
            sensor    = ($urandom_range(0, 9) == 0);
            rolhas    = ($urandom_range(0, 7) != 0);
            aprovada  = ($urandom_range(0, 11) == 0);
            reprovada = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) lote = ~lote;
            start     = ($urandom_range(0, 79) != 0);
            ciclo();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
